id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline register sitting directly upstream of the ALU. It captures decoded
//   operands, resolves data hazards by forwarding from EX/MEM and MEM/WB, and presents
//   in1/in2/ALUctrl to the ALU. It uses a valid/ready handshake with stall and flush.
// PARAMETERS
//   DATA_WIDTH  32  operand, immediate and PC width
//   REG_AW      5   register address width (x0..x31)
// PORTS
//   clk            in   1           rising-edge clock
//   rst_n          in   1           asynchronous active-low reset
//   id_valid       in   1           decode presents an instruction
//   id_ready       out  1           stage can accept this cycle
//   id_rs1_data    in   DATA_WIDTH  regfile read port 1
//   id_rs2_data    in   DATA_WIDTH  regfile read port 2
//   id_rs1/rs2/rd  in   REG_AW      source and destination register addresses
//   id_imm         in   DATA_WIDTH  sign-extended immediate
//   id_pc          in   DATA_WIDTH  instruction PC
//   id_src_a_pc    in   1           1: in1=PC, 0: in1=rs1 operand
//   id_src_b_imm   in   1           1: in2=imm, 0: in2=rs2 operand
//   id_alu_ctrl    in   3           ALU operation code
//   id_reg_write   in   1           instruction writes rd
//   flush          in   1           branch/jump kill (synchronous)
//   exm_rd/exm_we/exm_result   in  REG_AW/1/DATA_WIDTH  EX/MEM forwarding source
//   mwb_rd/mwb_we/mwb_result   in  REG_AW/1/DATA_WIDTH  MEM/WB forwarding source
//   ex_valid       out  1           payload valid toward the ALU
//   ex_ready       in   1           ALU/EX consumes this cycle
//   in1, in2       out  DATA_WIDTH  ALU operands
//   ALUctrl        out  3           registered id_alu_ctrl
//   ex_rd/ex_reg_write  out  REG_AW/1  registered destination info
//   ex_store_data  out  DATA_WIDTH  forwarded rs2 operand, independent of src_b
// BEHAVIOUR
// - Reset (async, rst_n=0): ex_valid=0; all payload registers=0; in1=in2=0 and ALUctrl=0.
// - id_ready = !ex_valid || ex_ready (combinational; no dependency on id_valid).
// - capture = id_valid && id_ready && !flush. On capture, the payload is registered
//   at the next edge and ex_valid=1. This gives 1-cycle latency from ID to the ALU.
// - No capture and ex_ready=1 gives ex_valid=0 next edge. ex_valid=1 and ex_ready=0
//   holds the payload.
// - flush=1: ex_valid=0 next edge regardless of ex_ready or id_valid. The incoming
//   instruction is dropped. Flush has top priority.
// - Forwarding at capture, per source operand s (rs1, rs2):
//   - Priority: exm_we && exm_rd==s && s!=0 -> exm_result.
//   - Else: mwb_we && mwb_rd==s && s!=0 -> mwb_result.
//   - Else: regfile data.
//   - x0 is never forwarded. A register operand for s==0 is forced to 0.
// - Hold refresh: while ex_valid && !ex_ready, if mwb_we && mwb_rd==stored rs && rs!=0,
//   the stored operand is overwritten with mwb_result. This prevents stale values
//   across stalls. EX/MEM does not refresh during hold.
// - in1 = src_a_pc ? pc_q : rs1_q and in2 = src_b_imm ? imm_q : rs2_q. Both are
//   combinational from registered fields; no extra cycle.
// - Data and ALUctrl are don't-care when ex_valid=0. They are not cleared except by reset.
// - Reset mid-stall discards the held instruction; the first cycle after reset has
//   id_ready=1.
// STRUCTURE
// - rv_pkg:
//   - alu_ctrl_e: 3-bit ALU op codes (ADD=3'd0, SUB=3'd1 ...).
//   - fwd_sel_e: {FWD_RF, FWD_EXM, FWD_MWB}.
//   - REG_AW and DATA_WIDTH defaults.
// - Sub-module fwd_unit: combinational; takes (rs, exm_*, mwb_*) and returns fwd_sel_e.
//   It is instantiated twice. Payload registers, handshake and hold refresh stay in
//   id_ex_stage.
// TESTING
// 1. Reset then idle -> ex_valid=0, id_ready=1. in1=in2=0.
// 2. Capture: rs1=5 (data 0x10), rs2=6 (data 0x20), src flags 0 -> next cycle
//    ex_valid=1, in1=0x10, in2=0x20.
// 3. Forward priority: rs1=7 with exm_rd=7 (0xAA) and mwb_rd=7 (0xBB) -> in1=0xAA.
//    rs1=0 with exm_rd=0 -> in1=0.
// 4. Stall: ex_ready=0 for 3 cycles, id_valid=1 -> id_ready=0 and payload stable.
//    mwb_rd=rs2 with 0x55 in cycle 2 -> in2=0x55 in cycle 3. Release -> next instr captured.
// 5. Flush with id_valid=1 and ex_valid=1 -> ex_valid=0 next edge; incoming dropped.
// 6. src_a_pc=1, pc=0x100, src_b_imm=1, imm=0xFFFFFFFC -> in1=0x100, in2=0xFFFFFFFC,
//    ex_store_data=forwarded rs2. Async rst_n pulse mid-stall -> immediate ex_valid=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types and width defaults for the ID/EX pipeline register and its forwarding logic.
package rv_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_AW     = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXM = 2'd1,
    FWD_MWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Forwarding source selector for one source register: EX/MEM beats MEM/WB, x0 never forwards.
module fwd_unit
  import rv_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] exm_rd_i,
  input  logic              exm_we_i,
  input  logic [REG_AW-1:0] mwb_rd_i,
  input  logic              mwb_we_i,
  output fwd_sel_e          sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (rs_i != '0) begin
      if (exm_we_i && (exm_rd_i == rs_i)) begin
        sel_o = FWD_EXM;
      end else if (mwb_we_i && (mwb_rd_i == rs_i)) begin
        sel_o = FWD_MWB;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: valid/ready handshake with flush, operand
// forwarding at capture, and MEM/WB refresh of held operands while stalled.
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [DATA_WIDTH-1:0] id_rs1_data,
  input  logic [DATA_WIDTH-1:0] id_rs2_data,
  input  logic [REG_AW-1:0]     id_rs1,
  input  logic [REG_AW-1:0]     id_rs2,
  input  logic [REG_AW-1:0]     id_rd,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic                  id_src_a_pc,
  input  logic                  id_src_b_imm,
  input  logic [2:0]            id_alu_ctrl,
  input  logic                  id_reg_write,
  input  logic                  flush,
  input  logic [REG_AW-1:0]     exm_rd,
  input  logic                  exm_we,
  input  logic [DATA_WIDTH-1:0] exm_result,
  input  logic [REG_AW-1:0]     mwb_rd,
  input  logic                  mwb_we,
  input  logic [DATA_WIDTH-1:0] mwb_result,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [DATA_WIDTH-1:0] in1,
  output logic [DATA_WIDTH-1:0] in2,
  output logic [2:0]            ALUctrl,
  output logic [REG_AW-1:0]     ex_rd,
  output logic                  ex_reg_write,
  output logic [DATA_WIDTH-1:0] ex_store_data
);

  function automatic logic [DATA_WIDTH-1:0] fwd_operand(
    input fwd_sel_e              sel,
    input logic [REG_AW-1:0]     rs,
    input logic [DATA_WIDTH-1:0] rf,
    input logic [DATA_WIDTH-1:0] exm,
    input logic [DATA_WIDTH-1:0] mwb
  );
    if (rs == '0) return '0;
    case (sel)
      FWD_EXM: return exm;
      FWD_MWB: return mwb;
      default: return rf;
    endcase
  endfunction

  fwd_sel_e sel_rs1, sel_rs2;

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_i(id_rs1), .exm_rd_i(exm_rd), .exm_we_i(exm_we),
    .mwb_rd_i(mwb_rd), .mwb_we_i(mwb_we), .sel_o(sel_rs1)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_i(id_rs2), .exm_rd_i(exm_rd), .exm_we_i(exm_we),
    .mwb_rd_i(mwb_rd), .mwb_we_i(mwb_we), .sel_o(sel_rs2)
  );

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [REG_AW-1:0]     rs1_q, rs2_q, rd_q;
  logic [DATA_WIDTH-1:0] pc_q, imm_q;
  logic                  src_a_pc_q, src_b_imm_q, reg_write_q;
  alu_ctrl_e             alu_q;
  logic                  capture, hold;

  assign id_ready = !valid_q || ex_ready;
  assign capture  = id_valid && id_ready && !flush;
  assign hold     = valid_q && !ex_ready;

  always_comb begin
    valid_d = valid_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
    end else if (ex_ready) begin
      valid_d = 1'b0;
    end
    if (capture) begin
      op1_d = fwd_operand(sel_rs1, id_rs1, id_rs1_data, exm_result, mwb_result);
      op2_d = fwd_operand(sel_rs2, id_rs2, id_rs2_data, exm_result, mwb_result);
    end else if (hold && mwb_we) begin
      // Only MEM/WB refreshes a held operand; EX/MEM's result will reach MEM/WB later.
      if ((rs1_q != '0) && (mwb_rd == rs1_q)) op1_d = mwb_result;
      if ((rs2_q != '0) && (mwb_rd == rs2_q)) op2_d = mwb_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      src_a_pc_q  <= 1'b0;
      src_b_imm_q <= 1'b0;
      reg_write_q <= 1'b0;
      alu_q       <= ALU_ADD;
    end else begin
      valid_q <= valid_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      if (capture) begin
        rs1_q       <= id_rs1;
        rs2_q       <= id_rs2;
        rd_q        <= id_rd;
        pc_q        <= id_pc;
        imm_q       <= id_imm;
        src_a_pc_q  <= id_src_a_pc;
        src_b_imm_q <= id_src_b_imm;
        reg_write_q <= id_reg_write;
        alu_q       <= alu_ctrl_e'(id_alu_ctrl);
      end
    end
  end

  assign ex_valid      = valid_q;
  assign in1           = src_a_pc_q  ? pc_q  : op1_q;
  assign in2           = src_b_imm_q ? imm_q : op2_q;
  assign ALUctrl       = alu_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_store_data = op2_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a transaction-level model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_src_a_pc, id_src_b_imm, id_reg_write, flush;
  logic [2:0]  id_alu_ctrl;
  logic [4:0]  exm_rd, mwb_rd;
  logic        exm_we, mwb_we;
  logic [31:0] exm_result, mwb_result;
  logic        ex_valid, ex_ready;
  logic [31:0] in1, in2, ex_store_data;
  logic [2:0]  ALUctrl;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_stage #(.DATA_WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm), .id_pc(id_pc),
    .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm), .id_alu_ctrl(id_alu_ctrl),
    .id_reg_write(id_reg_write), .flush(flush),
    .exm_rd(exm_rd), .exm_we(exm_we), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_we(mwb_we), .mwb_result(mwb_result),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .in1(in1), .in2(in2), .ALUctrl(ALUctrl),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently sitting in front of the ALU.
  typedef struct {
    bit        valid;
    bit [4:0]  rs1, rs2, rd;
    bit [31:0] op1, op2, pc, imm;
    bit        sa, sb, we;
    bit [2:0]  alu;
  } slot_t;
  slot_t m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] resolve(input bit [4:0] rs, input bit [31:0] rf);
    if (rs == 0) return 32'h0;
    if (exm_we && exm_rd == rs) return exm_result;
    if (mwb_we && mwb_rd == rs) return mwb_result;
    return rf;
  endfunction

  task automatic model_reset();
    m = '{default: '0};
  endtask

  task automatic idle();
    id_valid = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_src_a_pc = 0; id_src_b_imm = 0;
    id_reg_write = 0; id_alu_ctrl = 0; flush = 0; exm_rd = 0; exm_we = 0;
    exm_result = 0; mwb_rd = 0; mwb_we = 0; mwb_result = 0; ex_ready = 1;
  endtask

  // Compare outputs against the model, advance the model by one clock, return at the next negedge.
  task automatic step();
    bit stalled;
    #1;
    chk("ex_valid", {31'b0, ex_valid}, {31'b0, m.valid});
    chk("id_ready", {31'b0, id_ready}, {31'b0, !m.valid || ex_ready});
    if (m.valid) begin
      chk("in1", in1, m.sa ? m.pc : m.op1);
      chk("in2", in2, m.sb ? m.imm : m.op2);
      chk("alu", {29'b0, ALUctrl}, {29'b0, m.alu});
      chk("ex_rd", {27'b0, ex_rd}, {27'b0, m.rd});
      chk("ex_we", {31'b0, ex_reg_write}, {31'b0, m.we});
      chk("store", ex_store_data, m.op2);
    end
    stalled = m.valid && !ex_ready;
    if (flush) begin
      m.valid = 0;
    end else if (id_valid && !stalled) begin
      m.valid = 1;
      m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
      m.op1 = resolve(id_rs1, id_rs1_data);
      m.op2 = resolve(id_rs2, id_rs2_data);
      m.pc = id_pc; m.imm = id_imm; m.sa = id_src_a_pc; m.sb = id_src_b_imm;
      m.we = id_reg_write; m.alu = id_alu_ctrl;
    end else if (!stalled) begin
      m.valid = 0;
    end else if (mwb_we) begin
      if (m.rs1 != 0 && mwb_rd == m.rs1) m.op1 = mwb_result;
      if (m.rs2 != 0 && mwb_rd == m.rs2) m.op2 = mwb_result;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Reset then idle
    step();
    chk("rst_in1", in1, 32'h0);
    chk("rst_in2", in2, 32'h0);
    chk("rst_alu", {29'b0, ALUctrl}, 32'h0);

    // Plain capture
    id_valid = 1; id_rs1 = 5; id_rs1_data = 32'h10; id_rs2 = 6; id_rs2_data = 32'h20;
    id_rd = 4; id_reg_write = 1; id_alu_ctrl = 3'd1;
    step();
    idle();
    chk("cap_valid", {31'b0, ex_valid}, 32'h1);
    chk("cap_in1", in1, 32'h10);
    chk("cap_in2", in2, 32'h20);

    // Forward priority and x0
    id_valid = 1; id_rs1 = 7; id_rs1_data = 32'h77;
    exm_we = 1; exm_rd = 7; exm_result = 32'hAA;
    mwb_we = 1; mwb_rd = 7; mwb_result = 32'hBB;
    step();
    chk("fwd_exm", in1, 32'hAA);
    idle();
    id_valid = 1; id_rs1 = 0; id_rs1_data = 32'h99; exm_we = 1; exm_rd = 0; exm_result = 32'hCC;
    step();
    idle();
    chk("fwd_x0", in1, 32'h0);

    // Stall with MEM/WB refresh of held rs2
    id_valid = 1; id_rs1 = 5; id_rs1_data = 32'h10; id_rs2 = 6; id_rs2_data = 32'h20;
    step();
    idle();
    id_valid = 1; ex_ready = 0; id_rs1 = 9; id_rs1_data = 32'h123;
    step();
    chk("stall_rdy", {31'b0, id_ready}, 32'h0);
    chk("stall_in2", in2, 32'h20);
    mwb_we = 1; mwb_rd = 6; mwb_result = 32'h55;
    step();
    mwb_we = 0;
    chk("refresh_in2", in2, 32'h55);
    step();
    chk("stall_in1", in1, 32'h10);
    ex_ready = 1;
    step();
    chk("release_in1", in1, 32'h123);

    // Flush drops the incoming instruction
    id_valid = 1; flush = 1; id_rs1 = 3; id_rs1_data = 32'hDEAD;
    step();
    idle();
    chk("flush_valid", {31'b0, ex_valid}, 32'h0);

    // PC / immediate sources, store data keeps forwarded rs2
    id_valid = 1; id_src_a_pc = 1; id_pc = 32'h100; id_src_b_imm = 1; id_imm = 32'hFFFFFFFC;
    id_rs2 = 3; id_rs2_data = 32'h30; mwb_we = 1; mwb_rd = 3; mwb_result = 32'h333;
    step();
    idle();
    chk("pc_in1", in1, 32'h100);
    chk("imm_in2", in2, 32'hFFFFFFFC);
    chk("store_fwd", ex_store_data, 32'h333);

    // Async reset mid-stall
    ex_ready = 0; id_valid = 1;
    step();
    #3 rst_n = 0;
    #1;
    chk("arst_valid", {31'b0, ex_valid}, 32'h0);
    chk("arst_ready", {31'b0, id_ready}, 32'h1);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    idle();
    step();

    // Randomized traffic with a small register range to provoke hazards
    for (int i = 0; i < 500; i++) begin
      id_valid     = ($urandom_range(0, 9) < 7);
      ex_ready     = ($urandom_range(0, 9) < 6);
      flush        = ($urandom_range(0, 9) == 0);
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_rd        = 5'($urandom_range(0, 31));
      id_rs1_data  = $urandom;
      id_rs2_data  = $urandom;
      id_imm       = $urandom;
      id_pc        = $urandom;
      id_src_a_pc  = 1'($urandom_range(0, 1));
      id_src_b_imm = 1'($urandom_range(0, 1));
      id_reg_write = 1'($urandom_range(0, 1));
      id_alu_ctrl  = 3'($urandom_range(0, 7));
      exm_we       = 1'($urandom_range(0, 1));
      exm_rd       = 5'($urandom_range(0, 7));
      exm_result   = $urandom;
      mwb_we       = 1'($urandom_range(0, 1));
      mwb_rd       = 5'($urandom_range(0, 7));
      mwb_result   = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
